// File: rtl/wave_capture_pkg.sv
// ---------------------------------------------------------------------------
// wave_capture_pkg
// Shared definitions for the waveform capture buffer: default sample width,
// buffer depth and address width, the capture FSM state encoding, and a small
// helper that recognises a rising zero crossing from two sign bits.
// No ports (package).
// ---------------------------------------------------------------------------
package wave_capture_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 1024;
    localparam int ADDR_W_DEF = 10;

    // Encoding is visible to the host through state_o, so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FULL    = 2'd3
    } capState_t;

    // A rising zero crossing is "previous sample negative, current sample
    // non-negative". For two's complement samples that only needs the sign
    // bits, which keeps this helper independent of the sample width.
    function automatic logic risingZeroCross(input logic prevSign, input logic currSign);
        return prevSign && !currSign;
    endfunction

endpackage

// File: rtl/sample_ram.sv
// ---------------------------------------------------------------------------
// sample_ram
// Simple dual-port sample memory: one write port, one read port with a
// registered (1-cycle) read. No reset on the array or read register so that
// synthesis maps it onto block RAM.
// Ports:
//   i_clk     clock
//   i_wrEn    write strobe
//   i_wrAddr  write address
//   i_wrData  write data
//   i_rdEn    read strobe; read register only updates when this is high
//   i_rdAddr  read address
//   o_rdData  registered read data, valid the cycle after i_rdEn
// ---------------------------------------------------------------------------
module sample_ram
    import wave_capture_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic              i_rdEn,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [DATA_W-1:0] o_rdData
);

    localparam int WORDS = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [WORDS];

    // Write port: a plain synchronous write with no reset keeps this
    // recognisable as block RAM.
    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    // Read port: the output register only loads on a read strobe, so the
    // last word read stays on o_rdData until the next read.
    always_ff @(posedge i_clk) begin
        if (i_rdEn) begin
            o_rdData <= r_mem[i_rdAddr];
        end
    end

endmodule

// File: rtl/wave_capture_buffer.sv
// ---------------------------------------------------------------------------
// wave_capture_buffer
// Captures a decimated window of the summed oscillator waveform into a
// DEPTH-word buffer, optionally starting on a rising zero crossing, and then
// lets the host drain it one word per cycle.
// Ports:
//   clk           sole clock, rising edge
//   reset         synchronous active-high reset
//   sample_in     signed waveform sample
//   sample_valid  sample_in qualifier
//   arm           one-cycle pulse that (re)starts a capture from any state
//   trig_en       1 = wait for rising zero crossing, 0 = start immediately
//   decim         keep 1 of every decim+1 valid samples (latched on arm)
//   rd_en         host read strobe
//   rd_data       read word, one cycle after an accepted read, then held
//   count         words stored and not yet read
//   state_o       FSM state (IDLE/ARMED/CAPTURE/FULL)
//   underrun      sticky: read attempted while the buffer was not readable
// ---------------------------------------------------------------------------
module wave_capture_buffer
    import wave_capture_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    input  logic                     arm,
    input  logic                     trig_en,
    input  logic [15:0]              decim,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic [ADDR_W:0]          count,
    output logic [1:0]               state_o,
    output logic                     underrun
);

    localparam logic [ADDR_W:0] LAST_WRITE_COUNT = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] LAST_READ_COUNT  = (ADDR_W+1)'(1);

    capState_t                r_state;
    logic [ADDR_W:0]          r_count;
    logic [ADDR_W-1:0]        r_wrPtr;
    logic [ADDR_W-1:0]        r_rdPtr;
    logic [15:0]              r_decim;
    logic [15:0]              r_decimCnt;
    logic signed [DATA_W-1:0] r_prevSample;
    logic                     r_havePrev;
    logic                     r_underrun;
    logic                     r_rdLoaded;

    logic                     w_trigHit;
    logic                     w_store;
    logic                     w_rdAccept;
    logic                     w_lastWrite;
    logic                     w_lastRead;
    logic [DATA_W-1:0]        w_ramData;

    // The trigger needs a genuine previous sample from this capture; r_havePrev
    // is cleared on arm so the first sample after arm can never trigger, no
    // matter what was left in r_prevSample.
    assign w_trigHit = r_havePrev &&
                       risingZeroCross(r_prevSample[DATA_W-1], sample_in[DATA_W-1]);

    // Decide whether this cycle's sample goes into the buffer. Reset and arm
    // both override sampling; only ARMED (trigger) and CAPTURE (decimation)
    // ever store.
    always_comb begin
        w_store = 1'b0;
        if (!reset && !arm && sample_valid) begin
            case (r_state)
                ST_ARMED:   w_store = !trig_en || w_trigHit;
                ST_CAPTURE: w_store = (r_decimCnt == r_decim);
                default:    w_store = 1'b0;
            endcase
        end
    end

    // Reads are only honoured once the buffer is full and still has data;
    // arm takes priority over a read in the same cycle.
    assign w_rdAccept  = !reset && !arm && rd_en && (r_state == ST_FULL) && (r_count != '0);
    assign w_lastWrite = (r_count == LAST_WRITE_COUNT);
    assign w_lastRead  = (r_count == LAST_READ_COUNT);

    // Capture FSM plus its pointers, counters and flags. Priority order is
    // reset, then arm, then normal sampling/reading. Later assignments to
    // r_state in the normal branch intentionally override earlier ones, so a
    // trigger sample that also fills the buffer lands in FULL directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_decim      <= '0;
            r_decimCnt   <= '0;
            r_prevSample <= '0;
            r_havePrev   <= 1'b0;
            r_underrun   <= 1'b0;
            r_rdLoaded   <= 1'b0;
        end else if (arm) begin
            r_state    <= ST_ARMED;
            r_count    <= '0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_decim    <= decim;
            r_decimCnt <= '0;
            r_havePrev <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (sample_valid) begin
                r_prevSample <= sample_in;
                r_havePrev   <= 1'b1;
            end

            case (r_state)
                ST_ARMED: begin
                    if (w_store) begin
                        r_state    <= ST_CAPTURE;
                        r_decimCnt <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (sample_valid) begin
                        r_decimCnt <= w_store ? 16'd0 : r_decimCnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase

            if (w_store) begin
                r_wrPtr <= r_wrPtr + ADDR_W'(1);
                r_count <= r_count + (ADDR_W+1)'(1);
                if (w_lastWrite) begin
                    r_state <= ST_FULL;
                end
            end

            if (w_rdAccept) begin
                r_rdPtr    <= r_rdPtr + ADDR_W'(1);
                r_count    <= r_count - (ADDR_W+1)'(1);
                r_rdLoaded <= 1'b1;
                if (w_lastRead) begin
                    r_state <= ST_IDLE;
                end
            end

            if (rd_en && (r_state != ST_FULL)) begin
                r_underrun <= 1'b1;
            end
        end
    end

    sample_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_sampleRam (
        .i_clk    (clk),
        .i_wrEn   (w_store),
        .i_wrAddr (r_wrPtr),
        .i_wrData (sample_in),
        .i_rdEn   (w_rdAccept),
        .i_rdAddr (r_rdPtr),
        .o_rdData (w_ramData)
    );

    // The RAM read register has no reset, so rd_data is forced to zero until
    // the first read after reset has loaded it.
    assign rd_data  = r_rdLoaded ? w_ramData : '0;
    assign count    = r_count;
    assign state_o  = r_state;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_wave_capture_buffer.sv
// ---------------------------------------------------------------------------
// tb_wave_capture_buffer
// Directed bench for wave_capture_buffer. Read words are checked by a
// scoreboard: each read the driver issues pushes its expected word, and a
// monitor pops and compares whenever the DUT delivers a read word. Status
// outputs are checked directly by the driver.
// ---------------------------------------------------------------------------
module tb_wave_capture_buffer;

    localparam int ST_IDLE    = 0;
    localparam int ST_ARMED   = 1;
    localparam int ST_CAPTURE = 2;
    localparam int ST_FULL    = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] sample_in;
    logic               sample_valid;
    logic               arm;
    logic               trig_en;
    logic [15:0]        decim;
    logic               rd_en;
    logic [15:0]        rd_data;
    logic [10:0]        count;
    logic [1:0]         state_o;
    logic               underrun;

    int checks = 0;
    int errors = 0;
    int expQ[$];

    always #5 clk = ~clk;

    wave_capture_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .arm          (arm),
        .trig_en      (trig_en),
        .decim        (decim),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .count        (count),
        .state_o      (state_o),
        .underrun     (underrun)
    );

    // Compare one observed value against its expected value and keep score.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
        end
    endtask

    // Drive one clock cycle of inputs; returns 2 time units after the edge
    // so the monitor has already consumed any read word from this edge.
    task automatic applyStimulus(input logic v, input int s, input logic a, input logic r);
        @(negedge clk);
        sample_valid = v;
        sample_in    = 16'(s);
        arm          = a;
        rd_en        = r;
        @(posedge clk);
        #2;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic readWord(input int expected);
        expQ.push_back(expected);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic checkStatus(input string name, input int st, input int cnt, input int und);
        checkOutput({name, " state"}, int'(state_o), st);
        checkOutput({name, " count"}, int'(count), cnt);
        checkOutput({name, " underrun"}, int'(underrun), und);
    endtask

    // Monitor: a read strobe seen in FULL without arm/reset produces a word
    // right after that edge; pop the scoreboard and compare.
    always @(posedge clk) begin : monitor
        logic accepted;
        int   got;
        int   exp;
        accepted = rd_en && (state_o == 2'd3) && !arm && !reset;
        #1;
        if (accepted) begin
            checks++;
            got = int'($signed(rd_data));
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL rd_data unexpected word: actual %0d, required none", got);
            end else begin
                exp = expQ.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("[TB] FAIL rd_data word: actual %0d, required %0d", got, exp);
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        arm          = 1'b0;
        trig_en      = 1'b0;
        decim        = 16'd0;
        rd_en        = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkStatus("reset", ST_IDLE, 0, 0);
        checkOutput("reset rd_data", int'(rd_data), 0);
        @(negedge clk);
        reset = 1'b0;

        // Free-running capture of a full ramp, then drain it completely.
        trig_en = 1'b0;
        decim   = 16'd0;
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkStatus("ramp armed", ST_ARMED, 0, 0);
        for (int i = 0; i < 1024; i++) begin
            applyStimulus(1'b1, i, 1'b0, 1'b0);
            if (i == 0) checkStatus("ramp first", ST_CAPTURE, 1, 0);
        end
        checkStatus("ramp full", ST_FULL, 1024, 0);
        applyStimulus(1'b1, 9999, 1'b0, 1'b0);
        checkStatus("ramp drop", ST_FULL, 1024, 0);
        for (int i = 0; i < 1024; i++) begin
            readWord(i);
            if (i == 511) checkStatus("ramp half read", ST_FULL, 512, 0);
        end
        checkStatus("ramp drained", ST_IDLE, 0, 0);
        idleCycles(2);
        checkOutput("ramp rd_data hold", int'($signed(rd_data)), 1023);

        // Zero-crossing trigger; a negative sample before arm must not count.
        applyStimulus(1'b1, -5, 1'b0, 1'b0);
        trig_en = 1'b1;
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        applyStimulus(1'b1, 7, 1'b0, 1'b0);
        checkStatus("trig +7", ST_ARMED, 0, 0);
        applyStimulus(1'b1, -3, 1'b0, 1'b0);
        applyStimulus(1'b1, -1, 1'b0, 1'b0);
        applyStimulus(1'b0, 50, 1'b0, 1'b0);
        checkStatus("trig invalid", ST_ARMED, 0, 0);
        applyStimulus(1'b1, 2, 1'b0, 1'b0);
        checkStatus("trig +2", ST_CAPTURE, 1, 0);
        trig_en = 1'b0;
        applyStimulus(1'b1, 5, 1'b0, 1'b0);
        checkStatus("trig +5", ST_CAPTURE, 2, 0);
        for (int j = 2; j < 1024; j++) applyStimulus(1'b1, j + 100, 1'b0, 1'b0);
        checkStatus("trig full", ST_FULL, 1024, 0);
        readWord(2);
        readWord(5);
        for (int j = 2; j < 424; j++) readWord(j + 100);
        checkStatus("trig partial read", ST_FULL, 600, 0);

        // Reset in the middle of draining discards the buffer.
        @(negedge clk);
        reset = 1'b1;
        rd_en = 1'b0;
        @(posedge clk);
        #2;
        checkStatus("reset in full", ST_IDLE, 0, 0);
        checkOutput("reset in full rd_data", int'(rd_data), 0);
        @(negedge clk);
        reset = 1'b0;

        // Decimation by 4 with valid every other cycle; decim changes after
        // arm must be ignored.
        trig_en = 1'b0;
        decim   = 16'd3;
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        decim   = 16'd7;
        for (int k = 0; k < 4093; k++) begin
            applyStimulus(1'b1, k, 1'b0, 1'b0);
            applyStimulus(1'b0, -1234, 1'b0, 1'b0);
        end
        checkStatus("decim full", ST_FULL, 1024, 0);
        for (int k = 0; k < 8; k++) readWord(k * 4);
        checkStatus("decim read", ST_FULL, 1016, 0);

        // Read during capture flags underrun without touching count.
        decim = 16'd0;
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, i * 3, 1'b0, 1'b0);
        checkStatus("underrun pre", ST_CAPTURE, 10, 0);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        checkStatus("underrun set", ST_CAPTURE, 10, 1);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkStatus("underrun cleared", ST_ARMED, 0, 0);

        // Re-arm mid-capture restarts at address 0; arm beats the sample.
        for (int i = 0; i < 500; i++) applyStimulus(1'b1, i, 1'b0, 1'b0);
        checkStatus("rearm pre", ST_CAPTURE, 500, 0);
        applyStimulus(1'b1, 500, 1'b1, 1'b0);
        checkStatus("rearm", ST_ARMED, 0, 0);
        for (int i = 0; i < 1024; i++) applyStimulus(1'b1, 2000 + i, 1'b0, 1'b0);
        checkStatus("rearm full", ST_FULL, 1024, 0);
        readWord(2000);
        readWord(2001);
        readWord(2002);
        idleCycles(2);
        checkOutput("rearm rd_data hold", int'($signed(rd_data)), 2002);
        checkStatus("rearm read", ST_FULL, 1021, 0);

        checkOutput("scoreboard leftover", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
